// File: rtl/ps2_kb_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kb_cmd_seq
// Purpose  : Keyboard command sequencer between the system and the PS/2
//            transmitter/receiver pair. Issues the keyboard reset sequence
//            (FF, wait FA, wait BAT result AA) and the LED update sequence
//            (ED, wait FA, LED byte, wait FA). Handles FE resend requests,
//            transmit errors, reply timeouts and a bounded retry count.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            kb_reset_req        - pulse, request keyboard reset sequence
//            led_update          - pulse, request LED update sequence
//            led_state[2:0]      - {caps,num,scroll}, sampled at LED byte load
//            tx_data/tx_load     - byte and load strobe to the transmitter
//            tx_busy/tx_error    - transmitter status
//            rx_valid/rx_byte    - received byte strobe and value
//            rcv_enable          - receiver enable (low while transmitting)
//            cmd_busy            - sequence in progress
//            cmd_done            - pulse, sequence completed successfully
//            cmd_error           - sticky failure, cleared on next sequence
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kb_cmd_seq #(
    parameter logic [23:0] ACK_TIMEOUT   = 24'd600000,
    parameter logic [23:0] BAT_TIMEOUT   = 24'd14000000,
    parameter logic [1:0]  MAX_RETRY     = 2'd3,
    parameter logic        INIT_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_reset_req,
    input  logic       led_update,
    input  logic [2:0] led_state,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic       tx_error,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rcv_enable,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam logic [7:0] c_byte_reset = 8'hFF;
    localparam logic [7:0] c_byte_led   = 8'hED;
    localparam logic [7:0] c_byte_ack   = 8'hFA;
    localparam logic [7:0] c_byte_rsnd  = 8'hFE;
    localparam logic [7:0] c_byte_bat   = 8'hAA;
    localparam logic [7:0] c_byte_batf  = 8'hFC;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_tx   = 3'd2;
    localparam logic [2:0] c_st_ack  = 3'd3;
    localparam logic [2:0] c_st_bat  = 3'd4;
    localparam logic [2:0] c_st_fail = 3'd5;
    localparam logic [2:0] c_st_done = 3'd6;
    localparam logic [2:0] c_st_err  = 3'd7;

    logic [2:0]  r_state;
    logic        r_seq_rst;     // 1: reset sequence, 0: LED sequence
    logic        r_byte_idx;    // byte position within the sequence
    logic [1:0]  r_retry;
    logic [23:0] r_cnt;
    logic        r_pend_rst;
    logic        r_pend_led;
    logic        r_cmd_error;
    logic [7:0]  r_tx_data;

    logic [2:0]  w_state_next;
    logic        w_seq_rst_next;
    logic        w_idx_next;
    logic        w_start;
    logic        w_fa_accept;
    logic        w_retry_inc;
    logic        w_cnt_clear;
    logic [7:0]  w_load_byte;
    logic        w_rx_fa;
    logic        w_rx_fe;

    assign w_rx_fa = rx_valid && (rx_byte == c_byte_ack);
    assign w_rx_fe = rx_valid && (rx_byte == c_byte_rsnd);

    always_comb begin
        w_state_next   = r_state;
        w_seq_rst_next = r_seq_rst;
        w_idx_next     = r_byte_idx;
        w_start        = 1'b0;
        w_fa_accept    = 1'b0;
        w_retry_inc    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_pend_rst) begin
                    w_state_next   = c_st_load;
                    w_seq_rst_next = 1'b1;
                    w_idx_next     = 1'b0;
                    w_start        = 1'b1;
                end else if (r_pend_led) begin
                    w_state_next   = c_st_load;
                    w_seq_rst_next = 1'b0;
                    w_idx_next     = 1'b0;
                    w_start        = 1'b1;
                end
            end
            c_st_load: w_state_next = c_st_tx;
            c_st_tx: begin
                if (!tx_busy) begin
                    w_state_next = tx_error ? c_st_fail : c_st_ack;
                end
            end
            c_st_ack: begin
                // A FA/FE reply beats a coincident timeout; stray bytes do
                // not hold off the timeout, otherwise the count would run past
                // its terminal value.
                if (w_rx_fa) begin
                    w_fa_accept = 1'b1;
                    if (r_seq_rst) begin
                        w_state_next = c_st_bat;
                    end else if (!r_byte_idx) begin
                        w_state_next = c_st_load;
                        w_idx_next   = 1'b1;
                    end else begin
                        w_state_next = c_st_done;
                    end
                end else if (w_rx_fe) begin
                    w_state_next = c_st_fail;
                end else if (r_cnt == ACK_TIMEOUT - 24'd1) begin
                    w_state_next = c_st_fail;
                end
            end
            c_st_bat: begin
                if (rx_valid && (rx_byte == c_byte_bat)) begin
                    w_state_next = c_st_done;
                end else if (rx_valid && (rx_byte == c_byte_batf)) begin
                    w_state_next = c_st_err;
                end else if (r_cnt == BAT_TIMEOUT - 24'd1) begin
                    w_state_next = c_st_err;
                end
            end
            c_st_fail: begin
                if (r_retry < MAX_RETRY) begin
                    w_retry_inc  = 1'b1;
                    w_state_next = c_st_load;
                end else begin
                    w_state_next = c_st_err;
                end
            end
            c_st_done: w_state_next = c_st_idle;
            c_st_err:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Byte placed on tx_data when LOAD is entered; the LED byte captures
    // led_state at that moment.
    always_comb begin
        w_load_byte = c_byte_led;
        if (w_seq_rst_next) begin
            w_load_byte = c_byte_reset;
        end else if (w_idx_next) begin
            w_load_byte = {5'b0, led_state};
        end
    end

    assign w_cnt_clear = (w_state_next != r_state) &&
                         ((w_state_next == c_st_load) ||
                          (w_state_next == c_st_ack)  ||
                          (w_state_next == c_st_bat));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_seq_rst   <= 1'b0;
            r_byte_idx  <= 1'b0;
            r_retry     <= 2'd0;
            r_cnt       <= 24'd0;
            r_pend_rst  <= INIT_ON_RESET;
            r_pend_led  <= 1'b0;
            r_cmd_error <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_seq_rst  <= w_seq_rst_next;
            r_byte_idx <= w_idx_next;

            // Starting either sequence clears pend_led: a keyboard reset
            // leaves the LEDs dark, so a queued LED update is obsolete.
            r_pend_rst <= (r_pend_rst && !(w_start && w_seq_rst_next)) || kb_reset_req;
            r_pend_led <= (r_pend_led && !w_start) || led_update;

            if (w_start || w_fa_accept) begin
                r_retry <= 2'd0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 2'd1;
            end

            if (w_cnt_clear) begin
                r_cnt <= 24'd0;
            end else if ((r_state == c_st_ack) || (r_state == c_st_bat)) begin
                r_cnt <= r_cnt + 24'd1;
            end

            if (w_start) begin
                r_cmd_error <= 1'b0;
            end else if (w_state_next == c_st_err) begin
                r_cmd_error <= 1'b1;
            end

            if ((w_state_next == c_st_load) && (r_state != c_st_load)) begin
                r_tx_data <= w_load_byte;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_load    = (r_state == c_st_load);
    assign rcv_enable = !((r_state == c_st_load) || (r_state == c_st_tx));
    assign cmd_busy   = !((r_state == c_st_idle) || (r_state == c_st_done) ||
                          (r_state == c_st_err));
    assign cmd_done   = (r_state == c_st_done);
    assign cmd_error  = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kb_cmd_seq
// Purpose  : Self-checking bench for ps2_kb_cmd_seq. A bus model answers each
//            transmitted byte from a reply script; a scoreboard compares every
//            tx_load byte and every done/error event against queued
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kb_cmd_seq;

    localparam logic [23:0] c_ack_t = 24'd200;
    localparam logic [23:0] c_bat_t = 24'd3000;
    localparam int          c_limit = 6000;
    localparam int          c_ev_done = 1;
    localparam int          c_ev_err  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_reset_req = 1'b0;
    logic       led_update = 1'b0;
    logic [2:0] led_state = 3'b000;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy = 1'b0;
    logic       tx_error = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rcv_enable;
    logic       cmd_busy;
    logic       cmd_done;
    logic       cmd_error;

    ps2_kb_cmd_seq #(
        .ACK_TIMEOUT   (c_ack_t),
        .BAT_TIMEOUT   (c_bat_t),
        .MAX_RETRY     (2'd3),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kb_reset_req (kb_reset_req),
        .led_update   (led_update),
        .led_state    (led_state),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_busy      (tx_busy),
        .tx_error     (tx_error),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rcv_enable   (rcv_enable),
        .cmd_busy     (cmd_busy),
        .cmd_done     (cmd_done),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         txerr;
        bit         has1;
        int         d1;
        logic [7:0] b1;
        bit         has2;
        int         d2;
        logic [7:0] b2;
    } reply_t;

    reply_t     rq[$];
    logic [7:0] exp_tx[$];
    int         exp_ev[$];
    int         checks = 0;
    int         errors = 0;

    function automatic reply_t rep(bit txerr, bit h1, int d1, logic [7:0] b1,
                                   bit h2, int d2, logic [7:0] b2);
        reply_t r;
        r.txerr = txerr; r.has1 = h1; r.d1 = d1; r.b1 = b1;
        r.has2 = h2; r.d2 = d2; r.b2 = b2;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic rx_pulse(logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Bus model: busy for 5 cycles after each load, then replies per script.
    initial begin
        reply_t r;
        @(negedge clk);
        forever begin
            while (!(tx_load === 1'b1 && !rst)) @(negedge clk);
            if (rq.size() > 0) r = rq.pop_front();
            else r = rep(0, 0, 0, 8'h00, 0, 0, 8'h00);
            tx_busy = 1'b1;
            repeat (5) @(negedge clk);
            tx_busy  = 1'b0;
            tx_error = r.txerr;
            @(negedge clk);
            tx_error = 1'b0;
            if (r.has1) begin
                repeat (r.d1) @(negedge clk);
                rx_pulse(r.b1);
            end
            if (r.has2) begin
                repeat (r.d2) @(negedge clk);
                rx_pulse(r.b2);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_load) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hDEAD);
                    else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
                if (cmd_done) begin
                    if (exp_ev.size() == 0) chk("done_unexpected", 1, 0);
                    else chk("event_done", c_ev_done, exp_ev.pop_front());
                end
                if (cmd_error && !prev_err) begin
                    if (exp_ev.size() == 0) chk("error_unexpected", 1, 0);
                    else chk("event_error", c_ev_err, exp_ev.pop_front());
                end
            end
            prev_err = cmd_error;
        end
    end

    task automatic pulse_req(bit r, bit l);
        @(negedge clk);
        kb_reset_req = r;
        led_update   = l;
        @(negedge clk);
        kb_reset_req = 1'b0;
        led_update   = 1'b0;
    endtask

    task automatic wait_end(string name);
        int n;
        n = 0;
        while ((exp_ev.size() != 0 || cmd_busy) && n < c_limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished"}, (n < c_limit), 1);
        repeat (20) @(negedge clk);
        chk({name, "_tx_queue_empty"}, exp_tx.size(), 0);
        chk({name, "_idle"}, cmd_busy, 0);
    endtask

    task automatic chk_reset_outputs(string name);
        chk(name, {18'h0, tx_data, tx_load, rcv_enable, cmd_busy, cmd_done, cmd_error},
            {18'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        int n;
        // Reset state, then the power-on reset sequence.
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        exp_tx.push_back(8'hFF);
        rq.push_back(rep(0, 1, 3, 8'hFA, 1, 50, 8'hAA));
        exp_ev.push_back(c_ev_done);
        rst = 1'b0;
        wait_end("init_reset");

        // LED path: ED then 05.
        led_state = 3'b101;
        exp_tx.push_back(8'hED); exp_tx.push_back(8'h05);
        rq.push_back(rep(0, 1, 4, 8'hFA, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 4, 8'hFA, 0, 0, 8'h00));
        exp_ev.push_back(c_ev_done);
        pulse_req(0, 1);
        wait_end("led_path");
        chk("led_path_no_error", cmd_error, 0);

        // Reset path with a coincident LED request that the reset discards.
        exp_tx.push_back(8'hFF);
        rq.push_back(rep(0, 1, 3, 8'hFA, 1, 1000, 8'hAA));
        exp_ev.push_back(c_ev_done);
        pulse_req(1, 1);
        wait_end("reset_path");

        // LED byte answered FE twice, then FA.
        led_state = 3'b010;
        exp_tx.push_back(8'hED);
        repeat (3) exp_tx.push_back(8'h02);
        rq.push_back(rep(0, 1, 2, 8'hFA, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 2, 8'hFE, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 2, 8'hFE, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 2, 8'hFA, 0, 0, 8'h00));
        exp_ev.push_back(c_ev_done);
        pulse_req(0, 1);
        wait_end("retry");

        // Every ED answered FE: four sends then error.
        repeat (4) begin
            exp_tx.push_back(8'hED);
            rq.push_back(rep(0, 1, 2, 8'hFE, 0, 0, 8'h00));
        end
        exp_ev.push_back(c_ev_err);
        pulse_req(0, 1);
        wait_end("exhausted");
        chk("exhausted_error_flag", cmd_error, 1);

        // Stray 1C, then silence: resend after the ACK timeout.
        led_state = 3'b111;
        exp_tx.push_back(8'hED); exp_tx.push_back(8'hED); exp_tx.push_back(8'h07);
        rq.push_back(rep(0, 1, 20, 8'h1C, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 3, 8'hFA, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 3, 8'hFA, 0, 0, 8'h00));
        exp_ev.push_back(c_ev_done);
        pulse_req(0, 1);
        n = 0;
        while (!rcv_enable && n < 100) begin @(negedge clk); n++; end
        while (rcv_enable && n < 100) begin @(negedge clk); n++; end
        while (!rcv_enable && n < 100) begin @(negedge clk); n++; end
        chk("timeout_ack_entry_seen", (n < 100), 1);
        chk("timeout_error_cleared", cmd_error, 0);
        // ACK_TIMEOUT cycles in ACK plus the one FAIL cycle before LOAD.
        n = 0;
        while (!tx_load && n < 1000) begin @(negedge clk); n++; end
        chk("timeout_resend_delay", n, c_ack_t + 1);
        wait_end("timeout");

        // Transmit error on ED: ED resent, then normal completion.
        led_state = 3'b001;
        exp_tx.push_back(8'hED); exp_tx.push_back(8'hED); exp_tx.push_back(8'h01);
        rq.push_back(rep(1, 0, 0, 8'h00, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 3, 8'hFA, 0, 0, 8'h00));
        rq.push_back(rep(0, 1, 3, 8'hFA, 0, 0, 8'h00));
        exp_ev.push_back(c_ev_done);
        pulse_req(0, 1);
        wait_end("tx_error");

        // rst mid-TX with simultaneous requests.
        led_state = 3'b100;
        exp_tx.push_back(8'hED);
        rq.push_back(rep(0, 0, 0, 8'h00, 0, 0, 8'h00));
        pulse_req(0, 1);
        n = 0;
        while (!tx_busy && n < 100) begin @(negedge clk); n++; end
        chk("midtx_busy_seen", (n < 100), 1);
        rst = 1'b1;
        kb_reset_req = 1'b1;
        led_update = 1'b1;
        @(negedge clk);
        kb_reset_req = 1'b0;
        led_update = 1'b0;
        repeat (10) @(negedge clk);
        chk_reset_outputs("midtx_reset_outputs");
        exp_tx.push_back(8'hFF);
        rq.push_back(rep(0, 1, 3, 8'hFA, 1, 50, 8'hAA));
        exp_ev.push_back(c_ev_done);
        rst = 1'b0;
        wait_end("midtx_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
